// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS register-file writeback path.
package mips_pkg;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 5;

    localparam logic [ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

    // One buffered register-file write.
    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Circular buffer with two write ports and one read port. Port 0 is the
// older write when both are used in the same cycle. DEPTH must be a power
// of two so the pointers wrap on their own.
module wb_fifo
    import mips_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr0_en,
    input  wb_entry_t        wr0_entry,
    input  logic             wr1_en,
    input  wb_entry_t        wr1_entry,
    input  logic             rd_en,
    output wb_entry_t        head,
    output logic             empty,
    output logic [CNT_W-1:0] free
);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr1_ptr;
    logic [CNT_W-1:0] count;
    logic             pop;
    wb_entry_t        slots [DEPTH];

    // Port 1 lands right behind port 0 when both write, else at the tail.
    assign wr1_ptr = wr0_en ? wr_ptr + PTR_W'(1) : wr_ptr;
    assign pop     = rd_en & (count != '0);

    assign head  = slots[rd_ptr];
    assign empty = (count == '0);
    assign free  = CNT_W'(DEPTH) - count;

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so every
        // block samples the pre-edge values regardless of evaluation order.
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(wr0_en) + PTR_W'(wr1_en);
            rd_ptr <= rd_ptr + PTR_W'(pop);
            count  <= count + CNT_W'(wr0_en) + CNT_W'(wr1_en) - CNT_W'(pop);
        end
    end

    // Entry storage.
    always_ff @(posedge clk) begin
        // NOTE: the storage array has no reset; the occupancy count alone
        // decides which slots hold live data, so clearing it buys nothing.
        if (wr0_en) slots[wr_ptr] <= wr0_entry;
        if (wr1_en) slots[wr1_ptr] <= wr1_entry;
    end

endmodule

// File: rtl/reg_writeback_unit.sv
// Write-side driver for the 32-entry register file. Merges ALU and load
// writebacks through a small FIFO, retires one write per cycle and tracks
// per-register outstanding writes for the hazard unit.
module reg_writeback_unit #(
    parameter int DATA_WIDTH = mips_pkg::DATA_WIDTH,
    parameter int ADDR_WIDTH = mips_pkg::ADDR_WIDTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  mem_valid_i,
    output logic                  mem_ready_o,
    input  logic [ADDR_WIDTH-1:0] mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_i,
    input  logic                  alu_valid_i,
    output logic                  alu_ready_o,
    input  logic [ADDR_WIDTH-1:0] alu_addr_i,
    input  logic [DATA_WIDTH-1:0] alu_data_i,
    output logic                  Reg_Write_o,
    output logic [ADDR_WIDTH-1:0] Write_Register_o,
    output logic [DATA_WIDTH-1:0] Write_Data_o,
    input  logic [ADDR_WIDTH-1:0] Read_Register_1_i,
    input  logic [ADDR_WIDTH-1:0] Read_Register_2_i,
    output logic                  rs_pending_o,
    output logic                  rt_pending_o,
    output logic                  idle_o
);

    localparam int CNT_W    = $clog2(FIFO_DEPTH + 1);
    localparam int SB_W     = $clog2(FIFO_DEPTH + 2);
    localparam int NUM_REGS = 1 << ADDR_WIDTH;

    localparam logic [SB_W:0] SB_ONE   = (SB_W + 1)'(1);
    localparam logic [SB_W:0] SB_LIMIT = {1'b0, {SB_W{1'b1}}};

    mips_pkg::wb_entry_t mem_entry;
    mips_pkg::wb_entry_t alu_entry;
    mips_pkg::wb_entry_t head;
    logic                empty;
    logic [CNT_W-1:0]    free;
    logic                mem_store;
    logic                alu_store;

    logic [SB_W-1:0] sb_cnt  [NUM_REGS];
    logic [SB_W:0]   sb_next [NUM_REGS];

    // Readies follow the registered occupancy only; a pop in the same
    // cycle does not open a slot early. The ALU yields the last slot to a
    // competing load.
    assign mem_ready_o = ~reset & (free >= CNT_W'(1));
    assign alu_ready_o = ~reset & ((free >= CNT_W'(2)) |
                                   ((free == CNT_W'(1)) & ~mem_valid_i));

    // Writes to register zero finish the handshake but are dropped here.
    assign mem_store = mem_valid_i & mem_ready_o & (mem_addr_i != mips_pkg::REG_ZERO);
    assign alu_store = alu_valid_i & alu_ready_o & (alu_addr_i != mips_pkg::REG_ZERO);

    assign mem_entry = '{addr: mem_addr_i, data: mem_data_i};
    assign alu_entry = '{addr: alu_addr_i, data: alu_data_i};

    // The load goes on port 0 so it is older than a same-cycle ALU write.
    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .wr0_en    (mem_store),
        .wr0_entry (mem_entry),
        .wr1_en    (alu_store),
        .wr1_entry (alu_entry),
        .rd_en     (1'b1),
        .head      (head),
        .empty     (empty),
        .free      (free)
    );

    // Retire the FIFO head into the register-file write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            Reg_Write_o      <= 1'b0;
            Write_Register_o <= '0;
            Write_Data_o     <= '0;
        end else begin
            Reg_Write_o <= ~empty;
            if (~empty) begin
                Write_Register_o <= head.addr;
                Write_Data_o     <= head.data;
            end
        end
    end

    // Next scoreboard value per register; one bit wider to expose overflow.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            // NOTE: each element gets its default before any conditional
            // update so no path leaves it unassigned and infers a latch.
            sb_next[r] = {1'b0, sb_cnt[r]};
            if (mem_store && (mem_addr_i == ADDR_WIDTH'(r)))
                sb_next[r] = sb_next[r] + SB_ONE;
            if (alu_store && (alu_addr_i == ADDR_WIDTH'(r)))
                sb_next[r] = sb_next[r] + SB_ONE;
            if (Reg_Write_o && (Write_Register_o == ADDR_WIDTH'(r)))
                sb_next[r] = sb_next[r] - SB_ONE;
        end
    end

    // Scoreboard counters; the range check holds by construction.
    always_ff @(posedge clk) begin
        if (reset) begin
            sb_cnt <= '{default: '0};
        end else begin
            for (int r = 0; r < NUM_REGS; r++) begin
                assert (sb_next[r] <= SB_LIMIT);
                sb_cnt[r] <= sb_next[r][SB_W-1:0];
            end
        end
    end

    assign rs_pending_o = (Read_Register_1_i != mips_pkg::REG_ZERO) &
                          (sb_cnt[Read_Register_1_i] != '0);
    assign rt_pending_o = (Read_Register_2_i != mips_pkg::REG_ZERO) &
                          (sb_cnt[Read_Register_2_i] != '0);

    assign idle_o = empty & ~Reg_Write_o;

endmodule

// File: tb/tb_reg_writeback_unit.sv
// Directed bench for reg_writeback_unit with a writeback scoreboard.
module tb_reg_writeback_unit;
    import mips_pkg::*;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          mem_valid_i;
    logic          mem_ready_o;
    logic [AW-1:0] mem_addr_i;
    logic [DW-1:0] mem_data_i;
    logic          alu_valid_i;
    logic          alu_ready_o;
    logic [AW-1:0] alu_addr_i;
    logic [DW-1:0] alu_data_i;
    logic          Reg_Write_o;
    logic [AW-1:0] Write_Register_o;
    logic [DW-1:0] Write_Data_o;
    logic [AW-1:0] Read_Register_1_i;
    logic [AW-1:0] Read_Register_2_i;
    logic          rs_pending_o;
    logic          rt_pending_o;
    logic          idle_o;

    always #5 clk = ~clk;

    reg_writeback_unit #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .mem_valid_i       (mem_valid_i),
        .mem_ready_o       (mem_ready_o),
        .mem_addr_i        (mem_addr_i),
        .mem_data_i        (mem_data_i),
        .alu_valid_i       (alu_valid_i),
        .alu_ready_o       (alu_ready_o),
        .alu_addr_i        (alu_addr_i),
        .alu_data_i        (alu_data_i),
        .Reg_Write_o       (Reg_Write_o),
        .Write_Register_o  (Write_Register_o),
        .Write_Data_o      (Write_Data_o),
        .Read_Register_1_i (Read_Register_1_i),
        .Read_Register_2_i (Read_Register_2_i),
        .rs_pending_o      (rs_pending_o),
        .rt_pending_o      (rt_pending_o),
        .idle_o            (idle_o)
    );

    int n_cmp  = 0;
    int n_fail = 0;
    int n_retired = 0;
    int ret_base;
    logic alu_blocked;

    wb_entry_t sb_q[$];
    wb_entry_t mem_pend[$];
    wb_entry_t alu_pend[$];
    wb_entry_t mon_e;

    // Reference occupancy: stores in, one pop per non-empty cycle.
    int m_count;
    int m_stores = 0;
    always @(posedge clk) begin
        if (reset) m_count <= 0;
        else       m_count <= m_count + m_stores - ((m_count != 0) ? 1 : 0);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Every retired write must match the oldest expected entry.
    always @(negedge clk) begin
        if (reset === 1'b0 && Reg_Write_o === 1'b1) begin
            n_retired++;
            if (sb_q.size() == 0) begin
                check("write_with_empty_scoreboard", Reg_Write_o, 1'b0);
            end else begin
                mon_e = sb_q.pop_front();
                check("wb_addr", Write_Register_o, mon_e.addr);
                check("wb_data", Write_Data_o, mon_e.data);
            end
        end
    end

    // Present pending requests each cycle until all are accepted.
    // Called and returns at 1 time unit after a rising edge.
    task automatic run_traffic();
        int   guard = 0;
        int   free_m;
        int   stores;
        logic exp_mr, exp_ar, acc_m, acc_a;
        while ((mem_pend.size() != 0 || alu_pend.size() != 0) && guard < 50) begin
            mem_valid_i = (mem_pend.size() != 0);
            alu_valid_i = (alu_pend.size() != 0);
            if (mem_valid_i) begin
                mem_addr_i = mem_pend[0].addr;
                mem_data_i = mem_pend[0].data;
            end
            if (alu_valid_i) begin
                alu_addr_i = alu_pend[0].addr;
                alu_data_i = alu_pend[0].data;
            end
            #1;
            free_m = DEPTH - m_count;
            exp_mr = (free_m >= 1);
            exp_ar = (free_m >= 2) || (free_m == 1 && !mem_valid_i);
            if (mem_valid_i) check("mem_ready", mem_ready_o, exp_mr);
            if (alu_valid_i) check("alu_ready", alu_ready_o, exp_ar);
            if (alu_valid_i && !exp_ar) alu_blocked = 1'b1;
            acc_m  = mem_valid_i && exp_mr;
            acc_a  = alu_valid_i && exp_ar;
            stores = 0;
            if (acc_m && mem_pend[0].addr != REG_ZERO) begin
                sb_q.push_back(mem_pend[0]);
                stores++;
            end
            if (acc_a && alu_pend[0].addr != REG_ZERO) begin
                sb_q.push_back(alu_pend[0]);
                stores++;
            end
            m_stores = stores;
            @(posedge clk);
            #1;
            m_stores = 0;
            if (acc_m) void'(mem_pend.pop_front());
            if (acc_a) void'(alu_pend.pop_front());
            guard++;
        end
        mem_valid_i = 1'b0;
        alu_valid_i = 1'b0;
        check("traffic_accepted", mem_pend.size() + alu_pend.size(), 0);
        mem_pend.delete();
        alu_pend.delete();
    endtask

    // Bounded wait for the unit to drain.
    task automatic wait_idle();
        int g = 0;
        while (idle_o !== 1'b1 && g < 20) begin
            @(posedge clk);
            #1;
            g++;
        end
        check("idle_reached", idle_o, 1'b1);
        check("scoreboard_drained", sb_q.size(), 0);
    endtask

    initial begin
        reset             = 1'b1;
        mem_valid_i       = 1'b0;
        alu_valid_i       = 1'b0;
        mem_addr_i        = '0;
        mem_data_i        = '0;
        alu_addr_i        = '0;
        alu_data_i        = '0;
        Read_Register_1_i = '0;
        Read_Register_2_i = '0;
        alu_blocked       = 1'b0;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check("mem_ready_in_reset", mem_ready_o, 1'b0);
        check("alu_ready_in_reset", alu_ready_o, 1'b0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("rst_reg_write", Reg_Write_o, 1'b0);
        check("rst_write_reg", Write_Register_o, 0);
        check("rst_write_data", Write_Data_o, 0);
        check("rst_idle", idle_o, 1'b1);
        check("rst_rs_pending", rs_pending_o, 1'b0);
        check("rst_rt_pending", rt_pending_o, 1'b0);
        check("rst_mem_ready", mem_ready_o, 1'b1);
        check("rst_alu_ready", alu_ready_o, 1'b1);

        // Single ALU write and its pending window.
        Read_Register_1_i = 5'd8;
        alu_pend.push_back('{addr: 5'd8, data: 32'h0000_00AA});
        run_traffic();
        check("single_pending_after_accept", rs_pending_o, 1'b1);
        check("single_no_write_yet", Reg_Write_o, 1'b0);
        @(posedge clk);
        #1;
        check("single_reg_write", Reg_Write_o, 1'b1);
        check("single_write_reg", Write_Register_o, 8);
        check("single_pending_during_write", rs_pending_o, 1'b1);
        @(posedge clk);
        #1;
        check("single_write_one_cycle", Reg_Write_o, 1'b0);
        check("single_pending_cleared", rs_pending_o, 1'b0);
        wait_idle();

        // Simultaneous load and ALU: load retires first.
        mem_pend.push_back('{addr: 5'd9,  data: 32'h1111_1111});
        alu_pend.push_back('{addr: 5'd10, data: 32'h2222_2222});
        run_traffic();
        @(posedge clk);
        #1;
        check("dual_first_reg", Write_Register_o, 9);
        @(posedge clk);
        #1;
        check("dual_second_reg", Write_Register_o, 10);
        wait_idle();

        // Back-pressure: loads and six ALU requests competing.
        ret_base    = n_retired;
        alu_blocked = 1'b0;
        for (int i = 1; i <= 3; i++)
            mem_pend.push_back('{addr: AW'(i), data: 32'h100 + DW'(i)});
        for (int i = 0; i < 6; i++)
            alu_pend.push_back('{addr: (i == 5) ? 5'd17 : AW'(11 + i), data: 32'h200 + DW'(i)});
        run_traffic();
        check("alu_ready_dropped", alu_blocked, 1'b1);
        wait_idle();
        check("backpressure_retired", n_retired - ret_base, 9);

        // Two writes to one register: pending until the later retires.
        Read_Register_2_i = 5'd16;
        alu_pend.push_back('{addr: 5'd16, data: 32'h5});
        alu_pend.push_back('{addr: 5'd16, data: 32'h7});
        run_traffic();
        check("waw_pending_0", rt_pending_o, 1'b1);
        check("waw_first_data", Write_Data_o, 32'h5);
        @(posedge clk);
        #1;
        check("waw_pending_1", rt_pending_o, 1'b1);
        check("waw_second_data", Write_Data_o, 32'h7);
        @(posedge clk);
        #1;
        check("waw_pending_cleared", rt_pending_o, 1'b0);
        check("waw_final_data", Write_Data_o, 32'h7);
        wait_idle();

        // Register zero: handshake only.
        ret_base          = n_retired;
        Read_Register_1_i = 5'd0;
        alu_pend.push_back('{addr: 5'd0, data: 32'hDEAD_BEEF});
        run_traffic();
        for (int i = 0; i < 3; i++) begin
            check("zero_no_write", Reg_Write_o, 1'b0);
            check("zero_idle", idle_o, 1'b1);
            check("zero_not_pending", rs_pending_o, 1'b0);
            @(posedge clk);
            #1;
        end
        check("zero_retired", n_retired - ret_base, 0);

        // Reset with writes buffered and one in the output register.
        Read_Register_1_i = 5'd21;
        Read_Register_2_i = 5'd22;
        mem_pend.push_back('{addr: 5'd20, data: 32'h3030_3030});
        alu_pend.push_back('{addr: 5'd21, data: 32'h4141_4141});
        alu_pend.push_back('{addr: 5'd22, data: 32'h5252_5252});
        run_traffic();
        check("pre_reset_rs_pending", rs_pending_o, 1'b1);
        check("pre_reset_rt_pending", rt_pending_o, 1'b1);
        reset = 1'b1;
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        ret_base = n_retired;
        for (int i = 0; i < 4; i++) begin
            check("post_reset_no_write", Reg_Write_o, 1'b0);
            check("post_reset_idle", idle_o, 1'b1);
            check("post_reset_rs", rs_pending_o, 1'b0);
            check("post_reset_rt", rt_pending_o, 1'b0);
            @(posedge clk);
            #1;
        end
        check("post_reset_retired", n_retired - ret_base, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
